// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO hub: FSM states, bus-error codes,
// internal register offsets and the legacy peripheral address tags.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

  typedef logic [2:0] err_t;

  localparam err_t ERR_NONE     = 3'd0;
  localparam err_t ERR_RD_UNMAP = 3'd1;
  localparam err_t ERR_WR_UNMAP = 3'd2;
  localparam err_t ERR_TIMEOUT  = 3'd3;
  localparam err_t ERR_RO       = 3'd4;

  localparam logic [7:0] OFF_CLK_US   = 8'h00;
  localparam logic [7:0] OFF_CLK_MS   = 8'h04;
  localparam logic [7:0] OFF_CLK_S    = 8'h08;
  localparam logic [7:0] OFF_ERR_CODE = 8'h0C;
  localparam logic [7:0] OFF_ERR_ADDR = 8'h10;

  localparam logic [11:0] TAG_DMEM = 12'h000;
  localparam logic [11:0] TAG_VGA  = 12'h001;
  localparam logic [11:0] TAG_KBD  = 12'h002;
  localparam logic [11:0] TAG_HEX  = 12'h003;
  localparam logic [11:0] TAG_SW   = 12'h004;
  localparam logic [11:0] TAG_INT  = 12'hFFF;

endpackage

// File: rtl/mmio_timebase.sv
// Free-running us/ms/s time counters driven by a clock prescaler.
// Counters are CPU-loadable; a load in the same cycle as a tick wins.
module mmio_timebase
  import mmio_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_us,
  input  logic        ld_ms,
  input  logic        ld_s,
  input  logic [31:0] ld_val,
  output logic [31:0] clk_us,
  output logic [31:0] clk_ms,
  output logic [31:0] clk_s
);
  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre;
  logic [9:0]    ms_sub, s_sub;
  logic          us_tick, ms_tick, s_tick;

  assign us_tick = (pre == PW'(DIV - 1));
  assign ms_tick = us_tick && (ms_sub == 10'd999);
  assign s_tick  = ms_tick && (s_sub == 10'd999);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre    <= '0;
      ms_sub <= '0;
      s_sub  <= '0;
      clk_us <= '0;
      clk_ms <= '0;
      clk_s  <= '0;
    end else begin
      pre <= us_tick ? '0 : pre + 1'b1;
      if (us_tick) ms_sub <= ms_tick ? '0 : ms_sub + 10'd1;
      if (ms_tick) s_sub <= s_tick ? '0 : s_sub + 10'd1;
      // sub-counters keep their phase across CPU loads of the visible counters
      if (ld_us)        clk_us <= ld_val;
      else if (us_tick) clk_us <= clk_us + 32'd1;
      if (ld_ms)        clk_ms <= ld_val;
      else if (ms_tick) clk_ms <= clk_ms + 32'd1;
      if (ld_s)         clk_s  <= ld_val;
      else if (s_tick)  clk_s  <= clk_s + 32'd1;
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// CPU data-port hub: decodes addr[31:20] to external slaves or internal
// timer/error registers; reads wait on slv_ready with a timeout.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                    NUM_SLV = 8,
  parameter logic [NUM_SLV*12-1:0] SLV_TAG = {NUM_SLV{12'h000}},
  parameter logic [11:0]           INT_TAG = TAG_INT,
  parameter int                    CLK_HZ  = 50000000,
  parameter int                    TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_ack,
  output logic [31:0]           cpu_rdata,
  output logic [NUM_SLV-1:0]    slv_sel,
  output logic                  slv_we,
  output logic                  slv_re,
  output logic [19:0]           slv_addr,
  output logic [31:0]           slv_wdata,
  input  logic [NUM_SLV*32-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]    slv_ready,
  output logic                  irq_err
);
  localparam int            WW        = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [31:0]          addr_q, wdata_q, rdata_q, err_addr;
  logic [31:0]          new_err_addr, int_rdata, rd_mux;
  logic [31:0]          clk_us, clk_ms, clk_s;
  logic [NUM_SLV-1:0]   sel_q, hit_sel;
  logic [WW-1:0]        wait_cnt;
  err_t                 err_code, new_err, int_err;
  logic                 accept, is_int, is_ext, int_wr, rdy, timeout;
  logic                 ld_us, ld_ms, ld_s, err_clr;

  assign accept  = (state == ST_IDLE) && cpu_req;
  assign is_int  = (cpu_addr[31:20] == INT_TAG);
  assign is_ext  = !is_int && (|hit_sel);
  assign int_wr  = accept && is_int && cpu_we;
  assign rdy     = |(slv_ready & sel_q);
  assign timeout = (state == ST_READ) && !rdy && (wait_cnt == WAIT_LAST);

  // descending scan so the lowest matching slave index wins
  always_comb begin
    hit_sel = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (SLV_TAG[i*12 +: 12] == cpu_addr[31:20]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rd_mux = rd_mux | (slv_rdata[i*32 +: 32] & {32{sel_q[i]}});
    end
  end

  always_comb begin
    int_rdata = '0;
    int_err   = ERR_NONE;
    ld_us     = 1'b0;
    ld_ms     = 1'b0;
    ld_s      = 1'b0;
    err_clr   = 1'b0;
    case (cpu_addr[7:0])
      OFF_CLK_US:   begin int_rdata = clk_us; ld_us = int_wr; end
      OFF_CLK_MS:   begin int_rdata = clk_ms; ld_ms = int_wr; end
      OFF_CLK_S:    begin int_rdata = clk_s;  ld_s  = int_wr; end
      OFF_ERR_CODE: begin int_rdata = {29'd0, err_code}; err_clr = int_wr; end
      OFF_ERR_ADDR: begin
        int_rdata = err_addr;
        if (cpu_we) int_err = ERR_RO;
      end
      default:      int_err = cpu_we ? ERR_WR_UNMAP : ERR_RD_UNMAP;
    endcase
  end

  always_comb begin
    new_err      = ERR_NONE;
    new_err_addr = addr_q;
    if (accept) begin
      new_err_addr = cpu_addr;
      if (is_int)       new_err = int_err;
      else if (!is_ext) new_err = cpu_we ? ERR_WR_UNMAP : ERR_RD_UNMAP;
    end else if (timeout) begin
      new_err = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cpu_req) state_nxt = is_ext ? (cpu_we ? ST_WRITE : ST_READ) : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_READ:  if (rdy || timeout) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      sel_q    <= '0;
      wait_cnt <= '0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cpu_req) begin
          addr_q   <= cpu_addr;
          wdata_q  <= cpu_wdata;
          sel_q    <= is_ext ? hit_sel : '0;
          wait_cnt <= '0;
          rdata_q  <= (is_int && !cpu_we) ? int_rdata : '0;
        end
        ST_READ: begin
          if (rdy)          rdata_q  <= rd_mux;
          else if (timeout) rdata_q  <= '0;
          else              wait_cnt <= wait_cnt + 1'b1;
        end
        ST_RESP: sel_q <= '0;
        default: ;
      endcase
      // first error sticks; a same-cycle clear lets a fresh error through
      if (new_err != ERR_NONE && (err_code == ERR_NONE || err_clr)) begin
        err_code <= new_err;
        err_addr <= new_err_addr;
      end else if (err_clr) begin
        err_code <= ERR_NONE;
        err_addr <= '0;
      end
    end
  end

  assign cpu_busy  = (state != ST_IDLE);
  assign cpu_ack   = (state == ST_RESP);
  assign cpu_rdata = rdata_q;
  assign slv_sel   = sel_q;
  assign slv_we    = (state == ST_WRITE);
  assign slv_re    = (state == ST_READ) && (wait_cnt == '0);
  assign slv_addr  = addr_q[19:0];
  assign slv_wdata = wdata_q;
  assign irq_err   = (err_code != ERR_NONE);

  mmio_timebase #(.CLK_HZ(CLK_HZ)) u_tb (
    .clock  (clock),
    .reset  (reset),
    .ld_us  (ld_us),
    .ld_ms  (ld_ms),
    .ld_s   (ld_s),
    .ld_val (cpu_wdata),
    .clk_us (clk_us),
    .clk_ms (clk_ms),
    .clk_s  (clk_s)
  );

endmodule

// File: tb/tb_mmio_hub.sv
// Bench for mmio_hub: directed vector table, timer/reset corner sequences,
// then random accesses against a cycle-count based reference model.
module tb_mmio_hub;
  localparam int NUM_SLV = 8;
  localparam int CLK_HZ  = 2000000;
  localparam int TIMEOUT = 4;
  localparam int DIV     = CLK_HZ / 1000000;
  localparam logic [NUM_SLV*12-1:0] SLV_TAG = {12'h008, 12'h007, 12'h006, 12'h005,
                                               12'h004, 12'h003, 12'h002, 12'h001};

  logic                  clock, reset;
  logic                  cpu_req, cpu_we;
  logic [31:0]           cpu_addr, cpu_wdata, cpu_rdata, slv_wdata;
  logic                  cpu_busy, cpu_ack, slv_we, slv_re, irq_err;
  logic [NUM_SLV-1:0]    slv_sel, slv_ready;
  logic [19:0]           slv_addr;
  logic [NUM_SLV*32-1:0] slv_rdata;

  mmio_hub #(.NUM_SLV(NUM_SLV), .SLV_TAG(SLV_TAG), .INT_TAG(12'hFFF),
             .CLK_HZ(CLK_HZ), .TIMEOUT(TIMEOUT)) u_dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .slv_sel(slv_sel),
    .slv_we(slv_we), .slv_re(slv_re), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ready(slv_ready),
    .irq_err(irq_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // time model: edge n after reset is a us tick when n is a multiple of DIV
  int unsigned m_n;
  logic [31:0] m_us, m_ms, m_s, s_us, s_ms, s_s;
  logic [2:0]  m_err;
  logic [31:0] m_eaddr;

  always @(posedge clock) begin
    if (reset) begin
      m_n <= 0; m_us <= 0; m_ms <= 0; m_s <= 0;
    end else begin
      m_n <= m_n + 1;
      if (cpu_req && cpu_we && cpu_addr[31:20] == 12'hFFF && cpu_addr[7:0] == 8'h00)
        m_us <= cpu_wdata;
      else if ((m_n + 1) % DIV == 0) m_us <= m_us + 1;
      if (cpu_req && cpu_we && cpu_addr[31:20] == 12'hFFF && cpu_addr[7:0] == 8'h04)
        m_ms <= cpu_wdata;
      else if ((m_n + 1) % (DIV * 1000) == 0) m_ms <= m_ms + 1;
      if (cpu_req && cpu_we && cpu_addr[31:20] == 12'hFFF && cpu_addr[7:0] == 8'h08)
        m_s <= cpu_wdata;
      else if ((m_n + 1) % (DIV * 1000000) == 0) m_s <= m_s + 1;
      if (cpu_req) begin s_us <= m_us; s_ms <= m_ms; s_s <= m_s; end
    end
  end

  task automatic do_acc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int dly, input logic [31:0] rd, input bit align,
                        output int cyc, output logic [31:0] rdat);
    logic [11:0] tg;
    logic [7:0]  off, oh;
    logic [31:0] e_rd;
    logic [2:0]  ne;
    bit          intr, ext, tmo, clr, busy_ok;
    int          tgt, e_cyc, n_we, n_re;
    tg = a[31:20]; off = a[7:0];
    intr = (tg == 12'hFFF);
    ext  = !intr && tg >= 12'd1 && tg <= 12'(NUM_SLV);
    tgt  = ext ? int'(tg) - 1 : 0;
    oh   = '0;
    if (ext) oh[tgt] = 1'b1;
    @(negedge clock);
    if (align) while (((m_n + 1) % DIV) != 0) @(negedge clock);
    chk("idle_busy", cpu_busy, 0);
    chk("idle_sel", slv_sel, 0);
    for (int i = 0; i < NUM_SLV; i++)
      slv_rdata[i*32 +: 32] = (ext && i == tgt) ? rd : (rd ^ 32'hFFFF_0000 ^ i);
    slv_ready = ext ? ~oh : '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    cyc = 0; rdat = '0; n_we = 0; n_re = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 20 && cyc == 0; k++) begin
      @(negedge clock);
      cpu_req = 1'b0;
      if (slv_we) begin
        n_we++;
        chk("we_sel", slv_sel, oh);
        chk("we_addr", slv_addr, a[19:0]);
        chk("we_data", slv_wdata, wd);
      end
      if (slv_re) begin
        n_re++;
        chk("re_sel", slv_sel, oh);
        chk("re_addr", slv_addr, a[19:0]);
      end
      if (!cpu_busy) busy_ok = 1'b0;
      if (cpu_ack) begin
        cyc  = k;
        rdat = cpu_rdata;
      end else if (ext && k == 1 + dly) begin
        slv_ready[tgt] = 1'b1;
      end
    end
    slv_ready = '0;
    // reference outcome from the address map and error rules
    tmo = ext && !we && dly >= TIMEOUT;
    if (!ext)    e_cyc = 1;
    else if (we) e_cyc = 2;
    else         e_cyc = tmo ? TIMEOUT + 1 : 2 + dly;
    e_rd = '0; ne = 3'd0; clr = 1'b0;
    if (intr) begin
      case (off)
        8'h00: e_rd = s_us;
        8'h04: e_rd = s_ms;
        8'h08: e_rd = s_s;
        8'h0C: if (we) clr = 1'b1; else e_rd = {29'd0, m_err};
        8'h10: if (we) ne = 3'd4; else e_rd = m_eaddr;
        default: ne = we ? 3'd2 : 3'd1;
      endcase
    end else if (!ext) begin
      ne = we ? 3'd2 : 3'd1;
    end else if (!we) begin
      if (tmo) ne = 3'd3; else e_rd = rd;
    end
    if (ne != 0 && (m_err == 0 || clr)) begin m_err = ne; m_eaddr = a; end
    else if (clr) begin m_err = 0; m_eaddr = 0; end
    chk("ack_cycle", cyc, e_cyc);
    chk("busy_during", busy_ok, 1);
    chk("we_count", n_we, (ext && we) ? 1 : 0);
    chk("re_count", n_re, (ext && !we) ? 1 : 0);
    if (!we) chk("rdata", rdat, e_rd);
    chk("irq_err", irq_err, (m_err != 0) ? 1 : 0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    int          dly;
    logic [31:0] rd;
    int          e_cyc;
    logic [31:0] e_rd;
    logic [2:0]  e_err;
  } vec_t;

  vec_t       tbl[17];
  logic [7:0] offs[8];
  int          cyc;
  logic [31:0] rdat;
  bit          saw_ack;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h03, 8'hFC};
    tbl[0]  = '{1'b0, 32'h0030_0004, 32'h0, 3, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 3'd0};
    tbl[1]  = '{1'b1, 32'h0030_0010, 32'h1234_5678, 0, 32'h0, 2, 32'h0, 3'd0};
    tbl[2]  = '{1'b0, 32'h0010_0000, 32'h0, 0, 32'h1111_1111, 2, 32'h1111_1111, 3'd0};
    tbl[3]  = '{1'b0, 32'h0080_0ABC, 32'h0, 1, 32'hA5A5_A5A5, 3, 32'hA5A5_A5A5, 3'd0};
    tbl[4]  = '{1'b0, 32'h0040_0008, 32'h0, 3, 32'h5A5A_0001, 5, 32'h5A5A_0001, 3'd0};
    tbl[5]  = '{1'b0, 32'h0050_0000, 32'h0, 4, 32'hDEAD_BEEF, 5, 32'h0, 3'd3};
    tbl[6]  = '{1'b0, 32'h1000_0000, 32'h0, 0, 32'h0, 1, 32'h0, 3'd3};
    tbl[7]  = '{1'b0, 32'hFFF0_000C, 32'h0, 0, 32'h0, 1, 32'h3, 3'd3};
    tbl[8]  = '{1'b0, 32'hFFF0_0010, 32'h0, 0, 32'h0, 1, 32'h0050_0000, 3'd3};
    tbl[9]  = '{1'b1, 32'hFFF0_000C, 32'h0, 0, 32'h0, 1, 32'h0, 3'd0};
    tbl[10] = '{1'b1, 32'h2000_0000, 32'h55, 0, 32'h0, 1, 32'h0, 3'd2};
    tbl[11] = '{1'b0, 32'hFFF0_0010, 32'h0, 0, 32'h0, 1, 32'h2000_0000, 3'd2};
    tbl[12] = '{1'b1, 32'hFFF0_000C, 32'h0, 0, 32'h0, 1, 32'h0, 3'd0};
    tbl[13] = '{1'b1, 32'hFFF0_0010, 32'h77, 0, 32'h0, 1, 32'h0, 3'd4};
    tbl[14] = '{1'b1, 32'hFFF0_000C, 32'h0, 0, 32'h0, 1, 32'h0, 3'd0};
    tbl[15] = '{1'b0, 32'hFFF0_0020, 32'h0, 0, 32'h0, 1, 32'h0, 3'd1};
    tbl[16] = '{1'b1, 32'hFFF0_000C, 32'h0, 0, 32'h0, 1, 32'h0, 3'd0};

    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    slv_rdata = '0; slv_ready = '0; m_err = 0; m_eaddr = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", cpu_busy, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_sel", slv_sel, 0);
    chk("rst_strobes", {slv_we, slv_re, irq_err}, 0);
    chk("rst_slv_addr", slv_addr, 0);
    chk("rst_slv_wdata", slv_wdata, 0);
    reset = 1'b0;

    repeat (2000) @(posedge clock);
    #1;
    chk("t2000_us", u_dut.clk_us, 1000);
    chk("t2000_ms", u_dut.clk_ms, 1);

    do_acc(1'b1, 32'hFFF0_0000, 32'hFFFF_FFFF, 0, 0, 1'b0, cyc, rdat);
    @(negedge clock);
    chk("us_wrap", u_dut.clk_us, 0);

    do_acc(1'b1, 32'hFFF0_0000, 32'h1234_0000, 0, 0, 1'b1, cyc, rdat);
    chk("us_load_on_tick", u_dut.clk_us, 32'h1234_0000);
    do_acc(1'b0, 32'hFFF0_0000, 0, 0, 0, 1'b0, cyc, rdat);

    for (int i = 0; i < 17; i++) begin
      do_acc(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].dly, tbl[i].rd, 1'b0, cyc, rdat);
      chk($sformatf("tbl%0d_cyc", i), cyc, tbl[i].e_cyc);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), rdat, tbl[i].e_rd);
      chk($sformatf("tbl%0d_err", i), u_dut.err_code, tbl[i].e_err);
    end

    @(negedge clock);
    slv_ready = '0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0030_0000;
    @(negedge clock);
    cpu_req = 1'b0;
    chk("mid_re", slv_re, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_sel", slv_sel, 0);
    chk("mid_busy", cpu_busy, 0);
    chk("mid_ack", cpu_ack, 0);
    chk("mid_re_drop", slv_re, 0);
    reset = 1'b0; m_err = 0; m_eaddr = 0; saw_ack = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (cpu_ack) saw_ack = 1'b1;
    end
    chk("mid_no_ack", saw_ack, 0);
    do_acc(1'b0, 32'h0030_0008, 0, 1, 32'h600D_F00D, 1'b0, cyc, rdat);
    chk("post_rst_rdata", rdat, 32'h600D_F00D);

    for (int it = 0; it < 300; it++) begin
      int          kind, dly;
      logic        we;
      logic [31:0] a, wd, rd;
      kind = $urandom_range(0, 5);
      wd   = $urandom;
      rd   = $urandom;
      dly  = $urandom_range(0, 6);
      we   = 1'($urandom_range(0, 1));
      case (kind)
        0, 1: a = {12'($urandom_range(1, NUM_SLV)), 20'($urandom)};
        2, 3: a = {12'hFFF, 12'($urandom), offs[$urandom_range(0, 7)]};
        4:    a = {12'($urandom_range(9, 4094)), 20'($urandom)};
        default: begin a = 32'hFFF0_000C; we = 1'b1; end
      endcase
      do_acc(we, a, wd, dly, rd, 1'b0, cyc, rdat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
Name: mmio_hub

Overview:
Parametrised memory-mapped I/O hub between the single-cycle CPU data port and up to NUM_SLV peripherals (data memory, VGA, keyboard, hex display, switches, ...).
- Decodes address tag addr[31:20] against a per-slave base table.
- Sequences reads with slave wait-states and a timeout.
- Contains the built-in us/ms/s time counters and a sticky bus-error capture block.
- Replaces the ad-hoc fixed-latency read/write case statements in the top level.

Parameters:
NUM_SLV, 8, number of external slave ports (1..16)
SLV_TAG, {8{12'h000}}, packed NUM_SLV x 12-bit tag table; slave i owns addr[31:20]==SLV_TAG[i]; lowest index wins on duplicates
INT_TAG, 12'hFFF, tag of internal register region
CLK_HZ, 50000000, clock frequency; must be a multiple of 1000000
TIMEOUT, 255, max wait cycles for slv_ready before a timeout error (>=1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
cpu_req  in  1  access request, sampled only while cpu_busy=0
cpu_we  in  1  1=write, 0=read, qualified by cpu_req
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_busy  out  1  hub not idle; new requests ignored
cpu_ack  out  1  one-cycle pulse, access complete
cpu_rdata  out  32  read data, valid while cpu_ack=1
slv_sel  out  NUM_SLV  one-hot select, held for whole access
slv_we  out  1  one-cycle write strobe
slv_re  out  1  one-cycle read strobe
slv_addr  out  20  cpu_addr[19:0], registered
slv_wdata  out  32  registered write data
slv_rdata  in  NUM_SLV*32  packed slave read data
slv_ready  in  NUM_SLV  slave read data valid
irq_err  out  1  high while err_code != 0

Behaviour:
- Reset: FSM=IDLE; all outputs 0; counters, prescalers and err regs 0.
- FSM states IDLE, WRITE, READ, RESP.
- IDLE, cpu_req=1: register addr, wdata and decoded sel. External hit goes to WRITE or READ. Internal hit or miss goes straight to RESP with the internal result.
- WRITE: slv_we=1 for exactly one cycle, then RESP. Writes are posted; no slave wait.
- READ: slv_re=1 in the first READ cycle only.
  - Capture slv_rdata[sel] on the first cycle slv_ready[sel]=1, including the strobe cycle, then go to RESP.
  - After TIMEOUT cycles without ready: rdata=32'h0, log error 3, go to RESP.
- RESP: cpu_ack=1 for one cycle, then IDLE; slv_sel clears.
- Latency, req to ack: write 2 cycles; internal/miss 1 cycle; read 2+wait cycles.
- cpu_busy=1 in every state except IDLE.
- Unmapped tag: read returns 0 with error 1; write is dropped with error 2.
- Internal region is decoded on addr[7:0]. All offsets except 0x10 are R/W; a write loads the value.
  - 0x00 clk_us, 0x04 clk_ms, 0x08 clk_s.
  - 0x0C err_code: any write clears err_code and err_addr.
  - 0x10 err_addr: read-only; a write logs error 4.
  - Other offsets read 0 and log error 1 (read) or 2 (write).
- Timers:
  - us prescaler counts 0..CLK_HZ/1e6-1; wrap gives a us tick, and clk_us increments.
  - ms sub-counter wraps every 1000 us ticks and increments clk_ms; s sub-counter wraps every 1000 ms ticks and increments clk_s.
  - All counters wrap modulo 2^32.
  - A CPU write to a counter in the same cycle as its tick: the write wins and the tick is lost.
- Error capture is sticky-first: err_code/err_addr load only when err_code==0. A clear write and a new error in the same cycle: the new error is logged.
- Reset mid-access: the access is abandoned, no ack, all strobes drop next cycle.

Decomposition:
- Package mmio_pkg: state enum, error code constants (ERR_NONE=0, ERR_RD_UNMAP=1, ERR_WR_UNMAP=2, ERR_TIMEOUT=3, ERR_RO=4), internal offsets, existing tag macros as localparams.
- Sub-module mmio_timebase: prescaler plus us/ms/s counters with load ports. The FSM, decode and error logic stay in mmio_hub.

Test Plan:
- Slave 2 tag 12'h003, read 0x0030_0004, slv_ready asserted 3 cycles after slv_re, data 0xCAFEF00D -> cpu_ack 5 cycles after req, cpu_rdata=0xCAFEF00D, slv_addr=0x00004.
- Write 0x0030_0010 data 0x12345678 -> exactly one slv_we cycle with slv_sel=8'b00000100, slv_wdata=0x12345678; ack at cycle 2.
- Read with slv_ready held 0, TIMEOUT=4 -> cpu_rdata=0 and err_code=3, err_addr=request address, irq_err=1. A second unmapped read keeps err_code=3. A write to 0xFFF0_000C clears err_code to 0.
- CLK_HZ=2000000: 2000 cycles from reset -> clk_us=1000, clk_ms=1. Write clk_us=0xFFFFFFFF, then 2 cycles -> clk_us=0 (wrap).
- Write to 0xFFF0_0010 -> err_code=4. Write to 0xFFF0_0000 coinciding with a us tick -> clk_us equals the written value.
- Assert reset while in READ waiting -> next cycle FSM=IDLE, slv_sel=0, no cpu_ack. A new read after reset completes normally.
